mlsu_req_sched: RTL

// - Shares the single MLSU pe_req port between NrReq issue frontends, e.g. vector-LSU issue and matrix issue.
// - Round-robin arbitration, locked while the MLSU stalls.
// - MLSU load and store units retire independently, so the block orders loads against stores:
//   a request of the opposite type issues only once all outstanding ops of the other type have completed.
// - Caps total in-flight instructions at MaxOutstanding. Sits directly in front of the MLSU request queue.

---
 rtl/mlsu_pkg.sv | 28 ++
 rtl/mlsu_outst_cnt.sv | 36 +++
 rtl/mlsu_req_sched.sv | 90 +++++++++
 3 files changed

// File: rtl/mlsu_pkg.sv
// Shared MLSU types and the round-robin pick helper used by the MLSU-side arbiters.
package mlsu_pkg;

  typedef struct packed {
    logic       isLoad;
    logic [7:0] addr;
  } pe_req_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= 32); returns ptr if none set.
  function automatic int unsigned rr_pick(input logic [31:0] valid, input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (!found && k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mlsu_outst_cnt.sv
// Outstanding-instruction counter: +1 on issue, -1 on done, saturating at zero.
module mlsu_outst_cnt #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_i,
  input  logic            done_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            underflow_c;

  always_comb begin
    underflow_c = done_i && (cnt_q == '0);
    cnt_d       = cnt_q;
    if (issue_i && !done_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!issue_i && done_i && !underflow_c) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  // A completion with nothing outstanding means the MLSU and this block disagree.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow_c)
    else $warning("mlsu_outst_cnt: done pulse with zero outstanding");

endmodule

// File: rtl/mlsu_req_sched.sv
// Round-robin scheduler sharing the MLSU pe_req port, with load/store ordering and an in-flight cap.
module mlsu_req_sched #(
  parameter  int unsigned NrReq          = 2,
  parameter  int unsigned MaxOutstanding = 4,
  parameter  type         pe_req_t       = mlsu_pkg::pe_req_t,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1),
  localparam int unsigned IdxW           = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic    [NrReq-1:0]      req_valid_i,
  output logic    [NrReq-1:0]      req_ready_o,
  input  pe_req_t [NrReq-1:0]      req_i,
  output logic                     mlsu_req_valid_o,
  input  logic                     mlsu_req_ready_i,
  output pe_req_t                  mlsu_req_o,
  output logic    [IdxW-1:0]       gnt_idx_o,
  input  logic                     ld_done_i,
  input  logic                     st_done_i,
  output logic    [CntW-1:0]       ld_cnt_o,
  output logic    [CntW-1:0]       st_cnt_o,
  output logic                     idle_o
);
  import mlsu_pkg::*;

  logic [CntW-1:0]  ld_cnt, st_cnt;
  logic [CntW:0]    total;
  logic [NrReq-1:0] elig;
  logic [IdxW-1:0]  sel, rr_ptr_q, rr_ptr_nxt, lock_idx_q;
  logic             lock_q, hs, issue_ld, issue_st;

  // Eligibility: room under the cap and no outstanding ops of the opposite type.
  always_comb begin
    elig  = '0;
    total = (CntW+1)'(ld_cnt) + (CntW+1)'(st_cnt);
    for (int unsigned i = 0; i < NrReq; i++) begin
      elig[i] = req_valid_i[i] && (total < (CntW+1)'(MaxOutstanding))
                && (req_i[i].isLoad ? (st_cnt == '0) : (ld_cnt == '0));
    end
  end

  // Selection and zero-latency output path; a stalled request stays presented via the lock.
  always_comb begin
    sel              = lock_q ? lock_idx_q : IdxW'(rr_pick(32'(elig), 32'(rr_ptr_q), NrReq));
    mlsu_req_valid_o = lock_q | (|elig);
    mlsu_req_o       = req_i[sel];
    gnt_idx_o        = sel;
    hs               = mlsu_req_valid_o && mlsu_req_ready_i;
    req_ready_o      = '0;
    if (hs) req_ready_o[sel] = 1'b1;
    issue_ld         = hs && mlsu_req_o.isLoad;
    issue_st         = hs && !mlsu_req_o.isLoad;
    rr_ptr_nxt       = (sel == IdxW'(NrReq - 1)) ? '0 : sel + IdxW'(1);
    idle_o           = (ld_cnt == '0) && (st_cnt == '0) && !(|req_valid_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      rr_ptr_q   <= rr_ptr_nxt;
      lock_q     <= 1'b0;
    end else if (mlsu_req_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  mlsu_outst_cnt #(.CntW(CntW)) u_ld_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .issue_i (issue_ld),
    .done_i  (ld_done_i),
    .cnt_o   (ld_cnt)
  );

  mlsu_outst_cnt #(.CntW(CntW)) u_st_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .issue_i (issue_st),
    .done_i  (st_done_i),
    .cnt_o   (st_cnt)
  );

  assign ld_cnt_o = ld_cnt;
  assign st_cnt_o = st_cnt;

endmodule
